// File: rtl/ebus_xfer_if.sv
// Request, EBUS and result signals of the EBUS transfer sequencer; master = sequencer, slave = CTL/device side.
// The parity lines exist only when EBUS_PARITY_EN is defined.
interface ebus_xfer_if;
  logic        start;
  logic        isWrite;
  logic [6:0]  csIn;
  logic [2:0]  funcIn;
  logic [35:0] adIn;
  logic [6:0]  ebusCS;
  logic [2:0]  ebusFunc;
  logic        ebusDemand;
  logic [35:0] ebusDataOut;
  logic        ebusDataOE;
  logic        ebusXfer;
  logic [35:0] ebusDataIn;
  logic [35:0] rdData;
  logic        busy;
  logic        done;
  logic        timeout;
`ifdef EBUS_PARITY_EN
  logic        ebusParity;
  logic        ebusParityIn;
  logic        parityErr;

  modport master (
    input  start, isWrite, csIn, funcIn, adIn, ebusXfer, ebusDataIn, ebusParityIn,
    output ebusCS, ebusFunc, ebusDemand, ebusDataOut, ebusDataOE, rdData,
           busy, done, timeout, ebusParity, parityErr
  );
  modport slave (
    output start, isWrite, csIn, funcIn, adIn, ebusXfer, ebusDataIn, ebusParityIn,
    input  ebusCS, ebusFunc, ebusDemand, ebusDataOut, ebusDataOE, rdData,
           busy, done, timeout, ebusParity, parityErr
  );
`else
  modport master (
    input  start, isWrite, csIn, funcIn, adIn, ebusXfer, ebusDataIn,
    output ebusCS, ebusFunc, ebusDemand, ebusDataOut, ebusDataOE, rdData,
           busy, done, timeout
  );
  modport slave (
    output start, isWrite, csIn, funcIn, adIn, ebusXfer, ebusDataIn,
    input  ebusCS, ebusFunc, ebusDemand, ebusDataOut, ebusDataOE, rdData,
           busy, done, timeout
  );
`endif
endinterface

// File: rtl/ebus_xfer.sv
// EBUS transfer sequencer: latches an EDP request, runs demand/transfer with the device, returns read data.
// Start-to-done 4 cycles minimum; start outside IDLE is dropped; odd parity optional under EBUS_PARITY_EN.
module ebus_xfer #(
  parameter int TIMEOUT_CYCLES = 63
) (
  input  logic        masterClk,
  input  logic        eboxResetN,
  ebus_xfer_if.master bus
);
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(TIMEOUT_CYCLES);

  typedef enum logic [2:0] {
    S_IDLE, S_SETUP, S_DEMAND, S_RELEASE, S_DONE
  } state_e;

  state_e      state_q;
  logic        is_wr_q;
  logic [6:0]  cs_q;
  logic [2:0]  func_q;
  logic        demand_q;
  logic [35:0] wdat_q;
  logic        oe_q;
  logic [35:0] rdat_q;
  logic        busy_q;
  logic        done_q;
  logic        timeout_q;
  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;
  logic        abort_d;
`ifdef EBUS_PARITY_EN
  logic        par_q;
  logic        perr_q;
`endif

  // One counter bounds both the demand wait and a stuck transfer in RELEASE.
  always_comb begin
    cnt_d   = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CW'(1);
    abort_d = (cnt_d == CNT_MAX) &&
              (((state_q == S_DEMAND) && !bus.ebusXfer) ||
               ((state_q == S_RELEASE) && bus.ebusXfer));
  end

  always_ff @(posedge masterClk) begin
    if (!eboxResetN) begin
      state_q   <= S_IDLE;
      is_wr_q   <= 1'b0;
      cs_q      <= '0;
      func_q    <= '0;
      demand_q  <= 1'b0;
      wdat_q    <= '0;
      oe_q      <= 1'b0;
      rdat_q    <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      timeout_q <= 1'b0;
      cnt_q     <= '0;
`ifdef EBUS_PARITY_EN
      par_q     <= 1'b0;
      perr_q    <= 1'b0;
`endif
    end else begin
      done_q    <= 1'b0;
      timeout_q <= 1'b0;
      if (abort_d) begin
        state_q   <= S_IDLE;
        busy_q    <= 1'b0;
        timeout_q <= 1'b1;
        demand_q  <= 1'b0;
        cs_q      <= '0;
        func_q    <= '0;
        wdat_q    <= '0;
        oe_q      <= 1'b0;
        cnt_q     <= '0;
        // A read that never got its word returns zero; a RELEASE abort keeps the captured word.
        if ((state_q == S_DEMAND) && !is_wr_q) begin
          rdat_q <= '0;
        end
`ifdef EBUS_PARITY_EN
        par_q     <= 1'b0;
`endif
      end else begin
        case (state_q)
          S_IDLE: begin
            if (bus.start) begin
              state_q <= S_SETUP;
              busy_q  <= 1'b1;
              is_wr_q <= bus.isWrite;
              cs_q    <= bus.csIn;
              func_q  <= bus.funcIn;
              wdat_q  <= bus.isWrite ? bus.adIn : '0;
              oe_q    <= bus.isWrite;
`ifdef EBUS_PARITY_EN
              par_q   <= bus.isWrite ? ~^bus.adIn : 1'b0;
              perr_q  <= 1'b0;
`endif
            end
          end
          S_SETUP: begin
            state_q  <= S_DEMAND;
            demand_q <= 1'b1;
            cnt_q    <= '0;
          end
          S_DEMAND: begin
            if (bus.ebusXfer) begin
              state_q  <= S_RELEASE;
              demand_q <= 1'b0;
              cnt_q    <= '0;
              if (!is_wr_q) begin
                rdat_q <= bus.ebusDataIn;
`ifdef EBUS_PARITY_EN
                if (!(^{bus.ebusDataIn, bus.ebusParityIn})) begin
                  perr_q <= 1'b1;
                end
`endif
              end
            end else begin
              cnt_q <= cnt_d;
            end
          end
          S_RELEASE: begin
            if (!bus.ebusXfer) begin
              state_q <= S_DONE;
              done_q  <= 1'b1;
              cs_q    <= '0;
              func_q  <= '0;
              wdat_q  <= '0;
              oe_q    <= 1'b0;
`ifdef EBUS_PARITY_EN
              par_q   <= 1'b0;
`endif
            end else begin
              cnt_q <= cnt_d;
            end
          end
          S_DONE: begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
          end
          default: begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign bus.ebusCS      = cs_q;
  assign bus.ebusFunc    = func_q;
  assign bus.ebusDemand  = demand_q;
  assign bus.ebusDataOut = wdat_q;
  assign bus.ebusDataOE  = oe_q;
  assign bus.rdData      = rdat_q;
  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.timeout     = timeout_q;
`ifdef EBUS_PARITY_EN
  assign bus.ebusParity  = par_q;
  assign bus.parityErr   = perr_q;
`endif

endmodule

// File: tb/tb_ebus_xfer.sv
// Bench for ebus_xfer: directed transfers, expectations queued at issue and checked by a monitor on each done/timeout.
// A behavioural device answers demand after a programmable delay and holds transfer for a programmable time.
`timescale 1ns/1ps
module tb_ebus_xfer;
  localparam int T = 8;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  ebus_xfer_if bus();
  ebus_xfer #(.TIMEOUT_CYCLES(T)) dut (
    .masterClk (clk),
    .eboxResetN(rst_n),
    .bus       (bus)
  );

  typedef struct {
    bit          is_to;
    logic [35:0] rd;
    int          dem;
    int          lat;
    int          oe;
    logic [6:0]  cs;
    logic [2:0]  fn;
    logic [35:0] wd;
    logic        par;
    logic        perr;
  } exp_t;

  exp_t exp_q[$];
  int nvec = 0;
  int nfail = 0;
  int npulse = 0;
  int ntx = 0;

  int          dev_delay = -1;
  int          dev_hold = 1;
  logic [35:0] dev_data = '0;
  logic        dev_par = 1'b0;

  task automatic cmp(input string name, input logic [63:0] act, input logic [63:0] req);
    nvec++;
    if (act !== req) begin
      nfail++;
      $display("FAIL %s: got 'h%0h, expected 'h%0h", name, act, req);
    end
  endtask

  function automatic exp_t mk(input bit is_to, input logic [35:0] rd, input int dem, input int lat,
                              input int oe, input logic [6:0] cs, input logic [2:0] fn,
                              input logic [35:0] wd, input logic par, input logic perr);
    exp_t e;
    e.is_to = is_to; e.rd = rd; e.dem = dem; e.lat = lat; e.oe = oe;
    e.cs = cs; e.fn = fn; e.wd = wd; e.par = par; e.perr = perr;
    return e;
  endfunction

  // Device: counts demand cycles from the first one (index 0), raises transfer at dev_delay, drops it dev_hold later.
  initial begin
    int dcnt;
    bit act;
    dcnt = 0;
    act = 1'b0;
    bus.ebusXfer = 1'b0;
    bus.ebusDataIn = '0;
`ifdef EBUS_PARITY_EN
    bus.ebusParityIn = 1'b0;
`endif
    forever begin
      @(posedge clk);
      #1;
      if (bus.busy !== 1'b1) begin
        act = 1'b0;
        dcnt = 0;
        bus.ebusXfer = 1'b0;
        bus.ebusDataIn = '0;
      end else if (!act) begin
        if (bus.ebusDemand === 1'b1) begin
          act = 1'b1;
          dcnt = 0;
        end
      end else begin
        dcnt++;
      end
      if (act && dev_delay >= 0) begin
        if (dcnt == dev_delay) begin
          bus.ebusXfer = 1'b1;
          bus.ebusDataIn = dev_data;
`ifdef EBUS_PARITY_EN
          bus.ebusParityIn = dev_par;
`endif
        end else if (dcnt == dev_delay + dev_hold) begin
          bus.ebusXfer = 1'b0;
          bus.ebusDataIn = '0;
        end
      end
    end
  end

  // Monitor: profiles each transaction from busy rising and scores it on its done/timeout pulse.
  initial begin
    exp_t e;
    bit trk, prev_busy, chk_idle, wd_chg, cs_chg;
    int lat, dem, oec;
    logic [6:0] cs_s;
    logic [2:0] fn_s;
    logic [35:0] wd_s;
`ifdef EBUS_PARITY_EN
    logic par_s, perr_s;
    par_s = 1'b0;
    perr_s = 1'b0;
`endif
    trk = 0; prev_busy = 0; chk_idle = 0; wd_chg = 0; cs_chg = 0;
    lat = 0; dem = 0; oec = 0; cs_s = '0; fn_s = '0; wd_s = '0;
    forever begin
      @(negedge clk);
      if (chk_idle) begin
        cmp($sformatf("t%0d_busy_after_done", ntx), 64'(bus.busy), 64'd0);
        chk_idle = 0;
      end
      if (bus.busy === 1'b1 && !prev_busy) begin
        trk = 1; lat = 1; dem = 0; oec = 0;
        cs_s = bus.ebusCS; fn_s = bus.ebusFunc; wd_s = bus.ebusDataOut;
        wd_chg = 0; cs_chg = 0;
`ifdef EBUS_PARITY_EN
        par_s = bus.ebusParity;
        perr_s = bus.parityErr;
`endif
      end else if (trk) begin
        lat++;
      end
      if (trk) begin
        if (bus.ebusDemand === 1'b1) dem++;
        if (bus.ebusDataOE === 1'b1) begin
          oec++;
          if (bus.ebusDataOut !== wd_s) wd_chg = 1;
        end
        if (bus.busy === 1'b1 && bus.done !== 1'b1 &&
            (bus.ebusCS !== cs_s || bus.ebusFunc !== fn_s)) cs_chg = 1;
      end
      if (bus.done === 1'b1 || bus.timeout === 1'b1) begin
        ntx++;
        if (exp_q.size() == 0) begin
          nvec++;
          nfail++;
          $display("FAIL t%0d_unexpected_pulse: done=%0b timeout=%0b, expected no pulse",
                   ntx, bus.done, bus.timeout);
        end else begin
          e = exp_q.pop_front();
          cmp($sformatf("t%0d_pulse_kind", ntx), {62'd0, bus.done, bus.timeout},
              e.is_to ? 64'd1 : 64'd2);
          cmp($sformatf("t%0d_rdData", ntx), 64'(bus.rdData), 64'(e.rd));
          cmp($sformatf("t%0d_demand_cycles", ntx), 64'(dem), 64'(e.dem));
          cmp($sformatf("t%0d_latency", ntx), 64'(lat), 64'(e.lat));
          cmp($sformatf("t%0d_oe_cycles", ntx), 64'(oec), 64'(e.oe));
          cmp($sformatf("t%0d_cs", ntx), 64'(cs_s), 64'(e.cs));
          cmp($sformatf("t%0d_func", ntx), 64'(fn_s), 64'(e.fn));
          cmp($sformatf("t%0d_cs_func_held", ntx), 64'(cs_chg), 64'd0);
          if (e.oe > 0) begin
            cmp($sformatf("t%0d_wdata", ntx), 64'(wd_s), 64'(e.wd));
            cmp($sformatf("t%0d_wdata_held", ntx), 64'(wd_chg), 64'd0);
          end
`ifdef EBUS_PARITY_EN
          cmp($sformatf("t%0d_parity_out", ntx), 64'(par_s), 64'(e.par));
          cmp($sformatf("t%0d_parity_err", ntx), 64'(bus.parityErr), 64'(e.perr));
          cmp($sformatf("t%0d_parity_err_at_setup", ntx), 64'(perr_s), 64'd0);
`endif
        end
        if (bus.done === 1'b1) chk_idle = 1;
        trk = 0;
        npulse++;
      end
      prev_busy = (bus.busy === 1'b1);
    end
  end

  task automatic wait_pulses(input string name, input int target);
    int w;
    w = 0;
    while (npulse < target && w < 100) begin
      @(negedge clk);
      w++;
    end
    if (npulse < target) begin
      nvec++;
      nfail++;
      $display("FAIL %s_wait: %0d pulses seen, expected %0d within 100 cycles", name, npulse, target);
      exp_q.delete();
    end
    @(negedge clk);
  endtask

  task automatic run_xfer(input string name, input bit wr, input logic [6:0] cs, input logic [2:0] fn,
                          input logic [35:0] ad, input int dly, input int hold,
                          input logic [35:0] dd, input logic dpar, input exp_t e);
    int n0;
    dev_delay = dly; dev_hold = hold; dev_data = dd; dev_par = dpar;
    exp_q.push_back(e);
    n0 = npulse;
    @(negedge clk);
    bus.start = 1'b1; bus.isWrite = wr; bus.csIn = cs; bus.funcIn = fn; bus.adIn = ad;
    @(negedge clk);
    bus.start = 1'b0;
    wait_pulses(name, n0 + 1);
  endtask

  task automatic chk_zero(input string tag);
    cmp({tag, "_ebusCS"}, 64'(bus.ebusCS), 64'd0);
    cmp({tag, "_ebusFunc"}, 64'(bus.ebusFunc), 64'd0);
    cmp({tag, "_ebusDemand"}, 64'(bus.ebusDemand), 64'd0);
    cmp({tag, "_ebusDataOut"}, 64'(bus.ebusDataOut), 64'd0);
    cmp({tag, "_ebusDataOE"}, 64'(bus.ebusDataOE), 64'd0);
    cmp({tag, "_rdData"}, 64'(bus.rdData), 64'd0);
    cmp({tag, "_busy"}, 64'(bus.busy), 64'd0);
    cmp({tag, "_done"}, 64'(bus.done), 64'd0);
    cmp({tag, "_timeout"}, 64'(bus.timeout), 64'd0);
`ifdef EBUS_PARITY_EN
    cmp({tag, "_ebusParity"}, 64'(bus.ebusParity), 64'd0);
    cmp({tag, "_parityErr"}, 64'(bus.parityErr), 64'd0);
`endif
  endtask

  initial begin
    int n0, w;
    rst_n = 1'b0;
    bus.start = 1'b0; bus.isWrite = 1'b0; bus.csIn = '0; bus.funcIn = '0; bus.adIn = '0;
    repeat (2) @(negedge clk);
    chk_zero("reset");
    rst_n = 1'b1;
    @(negedge clk);

    // Write, transfer 3 cycles after demand, held 1 cycle: demand c2..c5, done c7.
    run_xfer("wr", 1'b1, 7'o14, 3'b101, 36'h123456789, 3, 1, 36'h0, 1'b0,
             mk(0, 36'h0, 4, 7, 6, 7'o14, 3'b101, 36'h123456789, 1'b0, 1'b0));
    // Read with immediate transfer: done in cycle 4.
    run_xfer("rd", 1'b0, 7'o03, 3'b001, 36'hFFFFFFFFF, 0, 1, 36'h987654321, 1'b0,
             mk(0, 36'h987654321, 1, 4, 0, 7'o03, 3'b001, 36'h0, 1'b0, 1'b0));
    // Read with no transfer: 8 demand cycles, timeout in cycle 10, rdData cleared.
    run_xfer("rd_to", 1'b0, 7'o55, 3'b110, 36'h0, -1, 1, 36'h0, 1'b0,
             mk(1, 36'h0, 8, 10, 0, 7'o55, 3'b110, 36'h0, 1'b0, 1'b0));
    // Read whose transfer sticks high: RELEASE bound expires, captured word kept.
    run_xfer("rd_stuck", 1'b0, 7'o07, 3'b011, 36'h0, 1, 100, 36'hABCDE0123, 1'b0,
             mk(1, 36'hABCDE0123, 2, 12, 0, 7'o07, 3'b011, 36'h0, 1'b0, 1'b0));
    // Write with no transfer: OE from SETUP through the last demand cycle.
    run_xfer("wr_to", 1'b1, 7'o11, 3'b100, 36'h5A5A5A5A5, -1, 1, 36'h0, 1'b0,
             mk(1, 36'hABCDE0123, 8, 10, 9, 7'o11, 3'b100, 36'h5A5A5A5A5, 1'b1, 1'b0));

    // start held every cycle: ignored while busy, accepted again the cycle after DONE.
    dev_delay = 0; dev_hold = 1; dev_data = 36'h0F0F0F0F0; dev_par = 1'b1;
    exp_q.push_back(mk(0, 36'hABCDE0123, 1, 4, 3, 7'o21, 3'b010, 36'hFEDCBA987, 1'b0, 1'b0));
    exp_q.push_back(mk(0, 36'h0F0F0F0F0, 1, 4, 0, 7'o62, 3'b111, 36'h0, 1'b0, 1'b0));
    n0 = npulse;
    @(negedge clk);
    bus.start = 1'b1; bus.isWrite = 1'b1; bus.csIn = 7'o21; bus.funcIn = 3'b010; bus.adIn = 36'hFEDCBA987;
    @(negedge clk);
    bus.isWrite = 1'b0; bus.csIn = 7'o62; bus.funcIn = 3'b111; bus.adIn = 36'h111111111;
    w = 0;
    do begin
      @(negedge clk);
      w++;
    end while (bus.done !== 1'b1 && w < 50);
    cmp("b2b_first_done", 64'(bus.done), 64'd1);
    @(negedge clk);
    cmp("b2b_idle_busy", 64'(bus.busy), 64'd0);
    @(negedge clk);
    cmp("b2b_setup_busy", 64'(bus.busy), 64'd1);
    cmp("b2b_setup_cs", 64'(bus.ebusCS), 64'(7'o62));
    bus.start = 1'b0;
    wait_pulses("b2b", n0 + 2);

    // Reset while demand is high, with a coincident start.
    dev_delay = -1;
    @(negedge clk);
    bus.start = 1'b1; bus.isWrite = 1'b1; bus.csIn = 7'o77; bus.funcIn = 3'b011; bus.adIn = 36'h0DEADBEEF;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (3) @(negedge clk);
    cmp("rst_pre_demand", 64'(bus.ebusDemand), 64'd1);
    rst_n = 1'b0;
    bus.start = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    bus.start = 1'b0;
    chk_zero("rst_mid");
    repeat (T + 4) @(negedge clk);
    cmp("rst_stays_idle", 64'(bus.busy), 64'd0);

`ifdef EBUS_PARITY_EN
    run_xfer("par_w1", 1'b1, 7'o01, 3'b001, 36'h000000001, 0, 1, 36'h0, 1'b0,
             mk(0, 36'h0, 1, 4, 3, 7'o01, 3'b001, 36'h000000001, 1'b0, 1'b0));
    run_xfer("par_w3", 1'b1, 7'o02, 3'b010, 36'h000000003, 0, 1, 36'h0, 1'b0,
             mk(0, 36'h0, 1, 4, 3, 7'o02, 3'b010, 36'h000000003, 1'b1, 1'b0));
    run_xfer("par_rd_bad", 1'b0, 7'o04, 3'b011, 36'h0, 0, 1, 36'h0, 1'b0,
             mk(0, 36'h0, 1, 4, 0, 7'o04, 3'b011, 36'h0, 1'b0, 1'b1));
    run_xfer("par_rd_good", 1'b0, 7'o05, 3'b100, 36'h0, 0, 1, 36'h000000001, 1'b0,
             mk(0, 36'h000000001, 1, 4, 0, 7'o05, 3'b100, 36'h0, 1'b0, 1'b0));
`endif

    repeat (4) @(negedge clk);
    cmp("queue_drained", 64'(exp_q.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule

// File: doc/ebus_xfer.md
# ebus_xfer

EBOX-side EBUS transfer sequencer sitting directly downstream of the EDP. For DATAO/CONO it takes the EDP AD word and drives it onto the EBUS with controller select, function and demand. For DATAI/CONI it captures the device's word and returns it to the EDP AR input path (ARL/ARR select EBUS). It runs the demand/transfer handshake with the addressed device and aborts with a timeout flag if the device never answers.

## Interface
- TIMEOUT_CYCLES, 63, maximum demand cycles with no transfer before abort; must be ≥ 2
- masterClk  in  1  EBOX clock; all state changes on rising edge
- eboxResetN  in  1  synchronous, active-low reset
- start  in  1  one-cycle request from CTL; sampled only in IDLE
- isWrite  in  1  1 = EBOX drives data (DATAO/CONO); 0 = device drives data (DATAI/CONI); sampled with start
- csIn  in  7  controller select; sampled with start
- funcIn  in  3  EBUS function code; sampled with start
- adIn  in  36  EDP AD word (bits 0:35); sampled with start
- ebusCS  out  7  registered controller select
- ebusFunc  out  3  registered function
- ebusDemand  out  1  demand to device
- ebusDataOut  out  36  write data
- ebusDataOE  out  1  EBOX drives the data lines
- ebusXfer  in  1  device transfer acknowledge
- ebusDataIn  in  36  device data
- rdData  out  36  captured read word to the AR mux
- busy  out  1  sequence in progress
- done  out  1  one-cycle completion pulse
- timeout  out  1  one-cycle abort pulse
- ebusParity  out  1  present only with EBUS_PARITY_EN
- ebusParityIn  in  1  present only with EBUS_PARITY_EN
- parityErr  out  1  present only with EBUS_PARITY_EN

## Operation
- States: IDLE, SETUP, DEMAND, RELEASE, DONE.
- IDLE: busy=0. When start=1, latch isWrite, csIn, funcIn and adIn, then go to SETUP. start in any other state is ignored, with no queueing.
- SETUP (1 cycle): ebusCS/ebusFunc show the latched values. On a write, ebusDataOut=latched AD and ebusDataOE=1. Next state is DEMAND; clear the timeout counter.
- DEMAND: ebusDemand=1.
  - If ebusXfer=1: on a read, capture ebusDataIn into rdData; go to RELEASE.
  - Otherwise, increment the counter. When the counter reaches TIMEOUT_CYCLES, go to IDLE, pulse timeout and drop everything. On a read timeout, rdData=0.
- RELEASE: ebusDemand=0. CS, function and write data stay held. Stay while ebusXfer=1. When ebusXfer=0, go to DONE. A stuck ebusXfer gets the same TIMEOUT_CYCLES bound, with the counter reset on entry: on expiry, pulse timeout and go to IDLE; rdData keeps the captured value.
- DONE (1 cycle): done=1, ebusCS=0, ebusFunc=0, ebusDataOE=0; go to IDLE.
- ebusCS/ebusFunc are 0 and ebusDataOE=0 in IDLE.
- done and timeout are never high in the same cycle.
- rdData holds its value until the next read completes or a read times out.
- Reset (eboxResetN=0 at an edge) wins over everything, including mid-DEMAND or RELEASE and a coincident start.
- Reset values: state=IDLE, all outputs 0 (ebusCS, ebusFunc, ebusDemand, ebusDataOut, ebusDataOE, rdData, busy, done, timeout, ebusParity, parityErr).

## Timing
- Cycle 0: start sampled at the edge ending cycle 0.
- Cycle 1: SETUP; busy=1, CS/function (and write data) valid.
- Cycle 2: ebusDemand=1 at the earliest.
- Transfer seen at edge k: ebusDemand=0 in cycle k+1.
- Transfer low seen at edge m: done=1 in cycle m+1.
- Minimum latency, start to done: 4 cycles (device asserts transfer in cycle 2 and drops it in cycle 3).
- busy is 1 from SETUP through DONE inclusive. The next start is accepted in the cycle after DONE.
- Timeout: demand is held at most TIMEOUT_CYCLES cycles. timeout pulses in the cycle after the last demand cycle, with busy=0 in that same cycle.
- The counter is $clog2(TIMEOUT_CYCLES+1) bits wide and saturates and never wraps.
- ebusXfer and ebusDataIn are sampled registered, with no combinational path to any output.

## Configuration
- EBUS_PARITY_EN defined:
  - ebusParity is the odd parity of ebusDataOut whenever ebusDataOE=1, else 0.
  - On read capture, the odd parity of ebusDataIn and ebusParityIn is checked. A mismatch sets parityErr, which stays set until the next start or reset. done still pulses normally.
- EBUS_PARITY_EN undefined: the three parity ports do not exist and there is no parity logic.

## Test plan
- Write: start, isWrite=1, csIn=7'o14, funcIn=3'b101, adIn=36'h123456789, device asserts transfer 3 cycles after demand and drops it 1 cycle later -> ebusDataOut=36'h123456789 with OE from SETUP through RELEASE; demand high exactly 4 cycles; done once; busy low the next cycle.
- Read: isWrite=0, device returns 36'h987654321 with immediate transfer -> rdData=36'h987654321, done in cycle 4, ebusDataOE never 1.
- Timeout: TIMEOUT_CYCLES=8, no transfer -> demand high for exactly 8 cycles, one timeout pulse, no done, rdData=0.
- Busy/back-to-back: start repeated every cycle during a transfer -> ignored; start in the cycle after DONE -> new SETUP the following cycle.
- Reset mid-DEMAND: eboxResetN=0 for one edge while demand is high -> next cycle all outputs 0, state IDLE, no done or timeout pulse.
- Parity (EBUS_PARITY_EN): write 36'h000000001 -> ebusParity=0; read 36'h0 with ebusParityIn=0 -> parityErr=1 after capture, cleared by the next start.
